r4_frame_loader: RTL and testbench

Upstream feeder for the radix-4 butterfly stage. It accepts one complex 4-bit sample per transfer on a valid/ready stream and packs four consecutive samples into a frame. Finished frames sit in a two-entry ping-pong buffer, and each frame is presented to the butterfly as parallel operands xr0..xr3 / xi0..xi3 under its own valid/ready handshake. This decouples the serial logic-analyser-driven sample feed from the butterfly's parallel input.

---
 rtl/r4_frame_loader.sv | 217 +++++++++++++++++++++
 tb/tb_r4_frame_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r4_frame_loader.sv
// ----------------------------------------------------------------------------
// r4_frame_loader
//
// Purpose:
//   Feeds the radix-4 butterfly stage. One complex DW-bit sample is accepted
//   per input transfer and four consecutive samples are packed into a frame.
//   Completed frames are held in a two-entry ping-pong buffer (A = 0, B = 1)
//   and presented as parallel operands xr0..xr3 / xi0..xi3 under their own
//   valid/ready handshake.
//
// Handshakes (both streams): a transfer happens on a rising edge of wb_clk_i
//   where valid && ready are both high. valid may be raised without waiting
//   for ready; once raised, the offered data is held until the transfer.
//   in_ready and frm_valid are decoded from registers only, so there is no
//   combinational path from frm_ready to in_ready or from in_valid to
//   frm_valid.
//
// Ports:
//   wb_clk_i     in   1    clock, rising edge
//   wb_rst_i     in   1    synchronous active-high reset
//   in_valid     in   1    sample offered on in_re/in_im
//   in_ready     out  1    loader can accept a sample
//   in_sof       in   1    start of frame (qualified by in_valid)
//   in_re/in_im  in   DW   sample, two's complement
//   frm_valid    out  1    complete frame presented
//   frm_ready    in   1    butterfly consumes the frame
//   xr0..xr3     out  DW   frame real parts, slot 0..3
//   xi0..xi3     out  DW   frame imaginary parts, slot 0..3
//   sof_err      out  1    sticky: a frame was aborted by a mid-frame in_sof
//   frm_cnt      out  8    frames delivered, modulo 256
//   dbg_state_o  out  4    per-buffer state {buffer B, buffer A}
//
// Configuration:
//   R4_LOADER_DIGITREV_EN  when defined, input transfer k of a frame is stored
//                          in slot {k[0],k[1]} (order 0,2,1,3); otherwise
//                          sample k goes to slot k.
// ----------------------------------------------------------------------------
module r4_frame_loader #(
    parameter int DW = 4
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          frm_valid,
    input  logic          frm_ready,
    output logic [DW-1:0] xr0,
    output logic [DW-1:0] xr1,
    output logic [DW-1:0] xr2,
    output logic [DW-1:0] xr3,
    output logic [DW-1:0] xi0,
    output logic [DW-1:0] xi1,
    output logic [DW-1:0] xi2,
    output logic [DW-1:0] xi3,
    output logic          sof_err,
    output logic [7:0]    frm_cnt,
    output logic [3:0]    dbg_state_o
);

    // Per-buffer life cycle. FILLING is not stored: it is implied by the
    // buffer being wr_sel with a non-zero slot count.
    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_e;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [DW-1:0] buf_re_q [2][4];
    logic [DW-1:0] buf_im_q [2][4];
    logic [1:0]    full_q,    full_d;
    logic          wr_sel_q,  wr_sel_d;
    logic          rd_sel_q,  rd_sel_d;
    logic [1:0]    slot_q,    slot_d;
    logic          sof_err_q, sof_err_d;
    logic [7:0]    frm_cnt_q, frm_cnt_d;

    // ------------------------------------------------------------------
    // Decoded control
    // ------------------------------------------------------------------
    logic       in_fire;
    logic       out_fire;
    logic       is_abort;
    logic       frame_done;
    logic [1:0] wr_slot;

    assign in_ready  = !full_q[wr_sel_q];
    assign frm_valid = full_q[rd_sel_q];

    always_comb begin
        in_fire    = in_valid && in_ready;
        out_fire   = frm_valid && frm_ready;
        // An sof on slot 0 is the normal frame start; anywhere else it
        // restarts the frame in the same buffer.
        is_abort   = in_sof && (slot_q != 2'd0);
        frame_done = !is_abort && (slot_q == 2'd3);

        if (is_abort) begin
            wr_slot = 2'd0;
        end else begin
`ifdef R4_LOADER_DIGITREV_EN
            wr_slot = {slot_q[0], slot_q[1]};
`else
            wr_slot = slot_q;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        slot_d    = slot_q;
        sof_err_d = sof_err_q;
        frm_cnt_d = frm_cnt_q;

        // Consume first: a completing write only ever targets wr_sel, and
        // when both flags are set in_ready is low, so the two updates never
        // touch the same flag in one cycle.
        if (out_fire) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
            frm_cnt_d        = frm_cnt_q + 8'd1;
        end

        if (in_fire) begin
            if (is_abort) begin
                sof_err_d = 1'b1;
                slot_d    = 2'd1;
            end else begin
                // Slot wraps 3 -> 0 naturally on frame completion.
                slot_d = slot_q + 2'd1;
            end
            if (frame_done) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            full_q    <= 2'b00;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            slot_q    <= 2'd0;
            sof_err_q <= 1'b0;
            frm_cnt_q <= 8'd0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < 4; s++) begin
                    buf_re_q[b][s] <= '0;
                    buf_im_q[b][s] <= '0;
                end
            end
        end else begin
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            slot_q    <= slot_d;
            sof_err_q <= sof_err_d;
            frm_cnt_q <= frm_cnt_d;
            if (in_fire) begin
                buf_re_q[wr_sel_q][wr_slot] <= in_re;
                buf_im_q[wr_sel_q][wr_slot] <= in_im;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: operands come straight from the presented buffer's storage,
    // so they cannot change while the frame waits for frm_ready.
    // ------------------------------------------------------------------
    assign xr0 = buf_re_q[rd_sel_q][0];
    assign xr1 = buf_re_q[rd_sel_q][1];
    assign xr2 = buf_re_q[rd_sel_q][2];
    assign xr3 = buf_re_q[rd_sel_q][3];
    assign xi0 = buf_im_q[rd_sel_q][0];
    assign xi1 = buf_im_q[rd_sel_q][1];
    assign xi2 = buf_im_q[rd_sel_q][2];
    assign xi3 = buf_im_q[rd_sel_q][3];

    assign sof_err = sof_err_q;
    assign frm_cnt = frm_cnt_q;

    // ------------------------------------------------------------------
    // Debug view of the per-buffer state machines
    // ------------------------------------------------------------------
    function automatic buf_state_e state_of(input logic is_full,
                                            input logic is_filling);
        if (is_full) begin
            return BUF_FULL;
        end else if (is_filling) begin
            return BUF_FILLING;
        end
        return BUF_EMPTY;
    endfunction

    buf_state_e st_a;
    buf_state_e st_b;

    assign st_a = state_of(full_q[0], !wr_sel_q && (slot_q != 2'd0));
    assign st_b = state_of(full_q[1],  wr_sel_q && (slot_q != 2'd0));

    assign dbg_state_o = {st_b, st_a};

endmodule

// File: tb/tb_r4_frame_loader.sv
// ----------------------------------------------------------------------------
// Testbench for r4_frame_loader.
// A frame-level model (queue of finished frames, list of partial samples)
// predicts in_ready, frm_valid, operands, sof_err and frm_cnt every cycle;
// directed tests add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_r4_frame_loader;
    localparam int DW = 4;
    localparam int FW = 8 * DW;

    // ---------------- clock / reset ----------------
    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof   = 1'b0;
    logic [DW-1:0] in_re    = '0;
    logic [DW-1:0] in_im    = '0;
    logic          frm_ready = 1'b0;
    logic          in_ready;
    logic          frm_valid;
    logic [DW-1:0] xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3;
    logic          sof_err;
    logic [7:0]    frm_cnt;
    logic [3:0]    dbg_state_o;

    always #5 wb_clk_i = ~wb_clk_i;

    r4_frame_loader #(.DW(DW)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sof      (in_sof),
        .in_re       (in_re),
        .in_im       (in_im),
        .frm_valid   (frm_valid),
        .frm_ready   (frm_ready),
        .xr0         (xr0),
        .xr1         (xr1),
        .xr2         (xr2),
        .xr3         (xr3),
        .xi0         (xi0),
        .xi1         (xi1),
        .xi2         (xi2),
        .xi3         (xi3),
        .sof_err     (sof_err),
        .frm_cnt     (frm_cnt),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- bookkeeping ----------------
    int checks       = 0;
    int failures     = 0;
    int stall_cycles = 0;
    bit mon_en       = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame word layout: {xr0,xr1,xr2,xr3,xi0,xi1,xi2,xi3}.
    logic [FW-1:0] exp_q[$];
    logic [DW-1:0] part_re [4];
    logic [DW-1:0] part_im [4];
    int            part_n  = 0;
    logic          m_err   = 1'b0;
    logic [7:0]    m_cnt   = 8'd0;
`ifdef R4_LOADER_DIGITREV_EN
    int perm [4] = '{0, 2, 1, 3};
`else
    int perm [4] = '{0, 1, 2, 3};
`endif

    always @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            exp_q.delete();
            part_n = 0;
            m_err  = 1'b0;
            m_cnt  = 8'd0;
        end else begin
            bit            m_in_fire;
            bit            m_out_fire;
            logic [FW-1:0] f;
            m_in_fire  = in_valid && (exp_q.size() < 2);
            m_out_fire = frm_ready && (exp_q.size() > 0);
            if (m_out_fire) begin
                void'(exp_q.pop_front());
                m_cnt = m_cnt + 8'd1;
            end
            if (m_in_fire) begin
                if (in_sof && part_n != 0) begin
                    m_err  = 1'b1;
                    part_n = 0;
                end
                part_re[part_n] = in_re;
                part_im[part_n] = in_im;
                part_n++;
                if (part_n == 4) begin
                    f = '0;
                    for (int s = 0; s < 4; s++) begin
                        f[FW-1-s*DW -: DW]   = part_re[perm[s]];
                        f[4*DW-1-s*DW -: DW] = part_im[perm[s]];
                    end
                    exp_q.push_back(f);
                    part_n = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge wb_clk_i) begin
        if (mon_en && !wb_rst_i) begin
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            chk("frm_valid", 64'(frm_valid), 64'(exp_q.size() > 0));
            chk("sof_err", 64'(sof_err), 64'(m_err));
            chk("frm_cnt", 64'(frm_cnt), 64'(m_cnt));
            if (exp_q.size() > 0)
                chk("frame", 64'({xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3}),
                    64'(exp_q[0]));
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic sof);
        int waited;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_sof   = sof;
        waited   = 0;
        forever begin
            @(negedge wb_clk_i);
            if (in_ready) break;
            stall_cycles++;
            waited++;
            if (waited > 64) begin
                chk("send_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge wb_clk_i);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [DW-1:0] e1, e2;
`ifdef R4_LOADER_DIGITREV_EN
        e1 = 4'd3; e2 = 4'd2;
`else
        e1 = 4'd2; e2 = 4'd3;
`endif
        wait_cycles(3);
        wb_rst_i = 1'b0;
        mon_en   = 1'b1;

        // Reset values
        @(negedge wb_clk_i);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_frm_valid", 64'(frm_valid), 64'd0);
        chk("rst_sof_err", 64'(sof_err), 64'd0);
        chk("rst_frm_cnt", 64'(frm_cnt), 64'd0);
        chk("rst_operands", 64'({xr0, xr1, xr2, xr3, xi0, xi1, xi2, xi3}), 64'd0);
        chk("rst_dbg_state", 64'(dbg_state_o), 64'd0);
        @(posedge wb_clk_i); #1;

        // Single frame, frm_ready high
        frm_ready = 1'b1;
        send(4'd1, 4'hF, 1'b1);
        send(4'd2, 4'hE, 1'b0);
        send(4'd3, 4'hD, 1'b0);
        send(4'd4, 4'hC, 1'b0);
        @(negedge wb_clk_i);
        chk("t1_frm_valid", 64'(frm_valid), 64'd1);
        chk("t1_xr", 64'({xr0, xr1, xr2, xr3}), 64'({4'd1, e1, e2, 4'd4}));
`ifdef R4_LOADER_DIGITREV_EN
        chk("t1_xi", 64'({xi0, xi1, xi2, xi3}), 64'({4'hF, 4'hD, 4'hE, 4'hC}));
`else
        chk("t1_xi", 64'({xi0, xi1, xi2, xi3}), 64'({4'hF, 4'hE, 4'hD, 4'hC}));
`endif
        @(negedge wb_clk_i);
        chk("t1_frm_cnt", 64'(frm_cnt), 64'd1);
        @(posedge wb_clk_i); #1;

        // Backpressure: 12 samples with frm_ready low
        do_reset();
        frm_ready = 1'b0;
        for (int k = 1; k <= 8; k++) send(4'(k), 4'(0 - k), (k % 4) == 1);
        @(negedge wb_clk_i);
        chk("t2_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge wb_clk_i); #1;
        fork
            begin
                for (int k = 9; k <= 12; k++) send(4'(k), 4'(0 - k), (k % 4) == 1);
            end
            begin
                wait_cycles(5);
                frm_ready = 1'b1;
            end
        join
        wait_cycles(12);
        @(negedge wb_clk_i);
        chk("t2_frm_cnt", 64'(frm_cnt), 64'd3);
        chk("t2_drained", 64'(frm_valid), 64'd0);
        @(posedge wb_clk_i); #1;

        // Abort by mid-frame sof
        do_reset();
        frm_ready = 1'b0;
        send(4'd1, 4'd1, 1'b1);
        send(4'd2, 4'd2, 1'b0);
        send(4'd3, 4'd3, 1'b0);
        send(4'd7, 4'd5, 1'b1);
        send(4'd8, 4'd6, 1'b0);
        send(4'd9, 4'd7, 1'b0);
        send(4'd10, 4'd8, 1'b0);
        @(negedge wb_clk_i);
        chk("t3_sof_err", 64'(sof_err), 64'd1);
        chk("t3_frm_valid", 64'(frm_valid), 64'd1);
`ifdef R4_LOADER_DIGITREV_EN
        chk("t3_xr", 64'({xr0, xr1, xr2, xr3}), 64'({4'd7, 4'd9, 4'd8, 4'd10}));
`else
        chk("t3_xr", 64'({xr0, xr1, xr2, xr3}), 64'({4'd7, 4'd8, 4'd9, 4'd10}));
`endif
        @(posedge wb_clk_i); #1;

        // Back-to-back streaming and frm_cnt wrap
        do_reset();
        frm_ready    = 1'b1;
        stall_cycles = 0;
        for (int k = 0; k < 256; k++) send(4'(k), ~4'(k), (k % 4) == 0);
        wait_cycles(3);
        @(negedge wb_clk_i);
        chk("t4_frm_cnt_64", 64'(frm_cnt), 64'd64);
        chk("t4_no_stall", 64'(stall_cycles), 64'd0);
        @(posedge wb_clk_i); #1;
        for (int k = 0; k < 768; k++) send(4'(k * 3), 4'(k), (k % 4) == 0);
        wait_cycles(3);
        @(negedge wb_clk_i);
        chk("t4_frm_cnt_wrap", 64'(frm_cnt), 64'd0);
        chk("t4_no_stall_2", 64'(stall_cycles), 64'd0);
        @(posedge wb_clk_i); #1;

        // Reset mid-frame
        do_reset();
        frm_ready = 1'b0;
        send(4'd5, 4'd5, 1'b1);
        send(4'd6, 4'd6, 1'b0);
        do_reset();
        send(4'd11, 4'd1, 1'b1);
        send(4'd12, 4'd2, 1'b0);
        send(4'd13, 4'd3, 1'b0);
        send(4'd14, 4'd4, 1'b0);
        @(negedge wb_clk_i);
        chk("t5_frm_valid", 64'(frm_valid), 64'd1);
`ifdef R4_LOADER_DIGITREV_EN
        chk("t5_xr", 64'({xr0, xr1, xr2, xr3}), 64'({4'd11, 4'd13, 4'd12, 4'd14}));
`else
        chk("t5_xr", 64'({xr0, xr1, xr2, xr3}), 64'({4'd11, 4'd12, 4'd13, 4'd14}));
`endif
        @(posedge wb_clk_i); #1;
        frm_ready = 1'b1;
        wait_cycles(3);
        @(negedge wb_clk_i);
        chk("t5_one_frame", 64'(frm_cnt), 64'd1);
        chk("t5_empty", 64'(frm_valid), 64'd0);
        @(posedge wb_clk_i); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
